// File: rtl/lcd_rx.sv
// -----------------------------------------------------------------------------
// lcd_rx -- passive receiver for a 4-bit monochrome LCD panel bus.
//
// The panel bus (FLM, CL1/LP, CL2/DCLK, M, DATA) is asynchronous to clk. Every
// bus input passes through a 2-flop synchronizer and one history flop. Falling
// edges of DCLK and LP are found from the synchronized copies only. A
// two-state FSM (WAIT_FRAME / IN_FRAME) tracks frame lock. Inside a frame every
// DCLK fall yields one pixel nibble with its (x, y) position, and every LP fall
// ends a line.
//
// Parameters
//   H_NIBBLES  nibbles per line (default 80 = 320 px)
//   V_LINES    lines per frame  (default 240)
//
// Ports
//   clk, rst_n                 sampling clock, async active-low reset
//   lcd_flm, lcd_cl1, lcd_cl2  frame marker, line latch, data shift clock
//   lcd_m, lcd_data[3:0]       AC-drive polarity, pixel nibble
//   err_clr                    synchronous clear of the sticky error flags
//   pix_data[3:0], pix_x[7:0], pix_y[8:0], pix_valid
//                              captured nibble, its position, 1-cycle strobe
//   frame_start, line_done     1-cycle event pulses
//   locked                     high while IN_FRAME (this is the FSM state)
//   fmt_err, m_err             sticky line-length/line-count and polarity flags
//
// Optional feature: define LCD_RX_M_CHECK_EN to latch lcd_m at each frame start
// and flag m_err when it did not toggle against the previous frame (the first
// frame after reset is not checked). Undefined: m_err is tied to 0.
//
// Handshake: pix_valid is a one-cycle strobe with no back-pressure; pix_data,
// pix_x and pix_y are meaningful only in the cycle pix_valid is high.
// -----------------------------------------------------------------------------
module lcd_rx #(
    parameter int H_NIBBLES = 80,
    parameter int V_LINES   = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_flm,
    input  logic       lcd_cl1,
    input  logic       lcd_cl2,
    input  logic       lcd_m,
    input  logic [3:0] lcd_data,
    input  logic       err_clr,
    output logic [3:0] pix_data,
    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start,
    output logic       line_done,
    output logic       locked,
    output logic       fmt_err,
    output logic       m_err
);

    localparam logic [7:0] H_MAX = 8'(H_NIBBLES);
    localparam logic [8:0] V_MAX = 9'(V_LINES);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        IN_FRAME   = 1'b1
    } state_e;

    // Bus vector: [7]=m, [6]=flm, [5]=cl1, [4]=cl2, [3:0]=data
    logic [7:0] bus_pin;
    logic [7:0] sync1_q, sync2_q, hist_q;

    assign bus_pin = {lcd_m, lcd_flm, lcd_cl1, lcd_cl2, lcd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= bus_pin;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    logic       dclk_fall, lp_fall, flm_s;
    logic [3:0] data_s;

    assign dclk_fall = hist_q[4] & ~sync2_q[4];
    assign lp_fall   = hist_q[5] & ~sync2_q[5];
    assign flm_s     = sync2_q[6];
    assign data_s    = sync2_q[3:0];

    // Only the clock bits need their history; the rest exist for uniformity.
    logic unused_hist;
    assign unused_hist = ^{hist_q[7:6], hist_q[3:0]};

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [3:0] pix_data_q, pix_data_d;
    logic       pix_valid_q, pix_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       line_done_q, line_done_d;
    logic       lp_pend_q, lp_pend_d;
    logic       fmt_err_q, fmt_err_d;
    logic       fmt_set, restart;
    logic [7:0] x_eff;
    logic       lp_evt;

    // pix_x holds the strobed index during pix_valid and advances one cycle
    // later; x_eff is the nibble count including that pending advance.
    assign x_eff = x_q + {7'd0, pix_valid_q};

    // A DCLK fall coinciding with an LP fall inside a frame defers the line
    // end by one cycle, so the nibble is strobed with its own x/y first.
    assign lp_evt = lp_pend_q | (lp_fall & ~(dclk_fall & (state_q == IN_FRAME)));

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        line_done_d   = 1'b0;
        lp_pend_d     = 1'b0;
        fmt_set       = 1'b0;
        restart       = 1'b0;

        if (pix_valid_q) begin
            x_d = x_eff;
        end

        case (state_q)
            WAIT_FRAME: begin
                if (lp_evt && flm_s) begin
                    restart = 1'b1;
                end
            end
            IN_FRAME: begin
                if (dclk_fall) begin
                    if (lp_fall) begin
                        lp_pend_d = 1'b1;
                    end
                    if ((x_eff < H_MAX) && (y_q < V_MAX)) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = data_s;
                    end else begin
                        fmt_set = 1'b1;
                    end
                end
                if (lp_evt) begin
                    if (y_q < V_MAX) begin
                        // End the current line; an FLM LP also closes the
                        // frame, whose completed line count is y_q + 1.
                        line_done_d = 1'b1;
                        if (x_eff != H_MAX) begin
                            fmt_set = 1'b1;
                        end
                        x_d = 8'd0;
                        y_d = y_q + 9'd1;
                        if (flm_s && ((y_q + 9'd1) != V_MAX)) begin
                            fmt_set = 1'b1;
                        end
                    end else if (!flm_s) begin
                        // Saturated: every further line is an extra line.
                        fmt_set = 1'b1;
                    end
                    if (flm_s) begin
                        restart = 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase

        if (restart) begin
            state_d       = IN_FRAME;
            frame_start_d = 1'b1;
            x_d           = 8'd0;
            y_d           = 9'd0;
        end
    end

    // A new error in the same cycle as err_clr leaves the flag set.
    assign fmt_err_d = fmt_set | (fmt_err_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_FRAME;
            x_q           <= 8'd0;
            y_q           <= 9'd0;
            pix_data_q    <= 4'd0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
            lp_pend_q     <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
            lp_pend_q     <= lp_pend_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

`ifdef LCD_RX_M_CHECK_EN
    logic m_last_q, m_last_d;
    logic m_seen_q, m_seen_d;
    logic m_err_q, m_err_d;
    logic m_set;

    // The polarity must alternate frame to frame; the first frame after
    // reset has no predecessor and is only recorded.
    assign m_set    = restart & m_seen_q & (sync2_q[7] == m_last_q);
    assign m_last_d = restart ? sync2_q[7] : m_last_q;
    assign m_seen_d = m_seen_q | restart;
    assign m_err_d  = m_set | (m_err_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_q <= 1'b0;
            m_seen_q <= 1'b0;
            m_err_q  <= 1'b0;
        end else begin
            m_last_q <= m_last_d;
            m_seen_q <= m_seen_d;
            m_err_q  <= m_err_d;
        end
    end

    assign m_err = m_err_q;
`else
    logic unused_m;
    assign unused_m = sync2_q[7];
    assign m_err    = 1'b0;
`endif

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign frame_start = frame_start_q;
    assign line_done   = line_done_q;
    assign locked      = (state_q == IN_FRAME);
    assign fmt_err     = fmt_err_q;

endmodule

// File: tb/tb_lcd_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_rx -- self-checking bench for lcd_rx.
//
// The DUT runs with H_NIBBLES = 80 and a short frame (V_LINES = 12) so that
// full frames stay short. Driver tasks move the panel bus at the falling clk
// edge and feed each bus event into a transaction-level model that pushes the
// expected strobes (pixel, line end, frame start) onto exp_q and tracks the
// expected sticky flags. One compare process pops exp_q for every DUT strobe.
// Polarity expectations follow LCD_RX_M_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_lcd_rx;

    localparam int H = 80;
    localparam int V = 12;
    localparam logic [1:0] K_PIX   = 2'd1;
    localparam logic [1:0] K_LINE  = 2'd2;
    localparam logic [1:0] K_FRAME = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       lcd_flm, lcd_cl1, lcd_cl2, lcd_m, err_clr;
    logic [3:0] lcd_data;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [8:0] pix_y;
    logic       frame_start, line_done, locked, fmt_err, m_err;

    lcd_rx #(
        .H_NIBBLES(H),
        .V_LINES  (V)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_flm    (lcd_flm),
        .lcd_cl1    (lcd_cl1),
        .lcd_cl2    (lcd_cl2),
        .lcd_m      (lcd_m),
        .lcd_data   (lcd_data),
        .err_clr    (err_clr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_start(frame_start),
        .line_done  (line_done),
        .locked     (locked),
        .fmt_err    (fmt_err),
        .m_err      (m_err)
    );

    // ---------------- scoreboard state ----------------
    // entry = {kind[1:0], data[3:0], x[7:0], y[8:0]}
    logic [22:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cnt_pix  = 0;
    int cnt_line = 0;
    int cnt_frame = 0;
    int p0, l0, f0;

    // ---------------- behavioural model ----------------
    bit md_in_frame;
    int md_x, md_y;
    bit md_fmt, md_merr;
`ifdef LCD_RX_M_CHECK_EN
    bit md_mlast, md_mseen;
`endif

    function automatic logic [22:0] mk(input logic [1:0] k, input logic [3:0] d,
                                       input logic [7:0] x, input logic [8:0] y);
        return {k, d, x, y};
    endfunction

    function automatic logic [3:0] pat(input int i, input int l);
        return 4'(i * 5 + l * 3 + 1);
    endfunction

    task automatic model_reset();
        md_in_frame = 1'b0;
        md_x = 0;
        md_y = 0;
        md_fmt = 1'b0;
        md_merr = 1'b0;
`ifdef LCD_RX_M_CHECK_EN
        md_mlast = 1'b0;
        md_mseen = 1'b0;
`endif
        exp_q.delete();
    endtask

    task automatic model_start();
`ifdef LCD_RX_M_CHECK_EN
        if (md_mseen && (lcd_m == md_mlast)) md_merr = 1'b1;
        md_mlast = lcd_m;
        md_mseen = 1'b1;
`endif
        md_in_frame = 1'b1;
        md_x = 0;
        md_y = 0;
        exp_q.push_back(mk(K_FRAME, 4'd0, 8'd0, 9'd0));
    endtask

    task automatic model_dclk(input logic [3:0] d);
        if (md_in_frame) begin
            if (md_x < H && md_y < V) begin
                exp_q.push_back(mk(K_PIX, d, 8'(md_x), 9'(md_y)));
                md_x++;
            end else begin
                md_fmt = 1'b1;
            end
        end
    endtask

    task automatic model_lp(input bit flm);
        if (!md_in_frame) begin
            if (flm) model_start();
        end else begin
            if (md_y < V) begin
                if (md_x != H) md_fmt = 1'b1;
                md_x = 0;
                md_y++;
                // a frame restart in the same cycle shows pix_y = 0
                exp_q.push_back(mk(K_LINE, 4'd0, 8'd0, flm ? 9'd0 : 9'(md_y)));
            end else if (!flm) begin
                md_fmt = 1'b1;
            end
            if (flm) begin
                if (md_y != V) md_fmt = 1'b1;
                model_start();
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_status(input string name);
        check({name, "_fmt_err"}, fmt_err, md_fmt);
        check({name, "_locked"}, locked, md_in_frame);
        check({name, "_m_err"}, m_err, md_merr);
    endtask

    task automatic check_q(input string name);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_evt(input logic [1:0] kind, input string name);
        logic [22:0] a, e;
        a = {kind, (kind == K_PIX) ? pix_data : 4'd0, pix_x, pix_y};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe x=%0d y=%0d, expected none", name, pix_x, pix_y);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d data=%0h x=%0d y=%0d, expected kind=%0d data=%0h x=%0d y=%0d",
                         name, a[22:21], a[20:17], a[16:9], a[8:0], e[22:21], e[20:17], e[16:9], e[8:0]);
            end
        end
    endtask

    // compare process: one sample per cycle, 2 ns after the active edge
    always begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            if (pix_valid)   begin cnt_pix++;   check_evt(K_PIX, "pix"); end
            if (line_done)   begin cnt_line++;  check_evt(K_LINE, "line_done"); end
            if (frame_start) begin cnt_frame++; check_evt(K_FRAME, "frame_start"); end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic nibble(input logic [3:0] d, input bit chk_lat);
        lcd_data = d;
        lcd_cl2  = 1'b1;
        tick(3);
        lcd_cl2 = 1'b0;
        model_dclk(d);
        if (chk_lat) begin
            tick(2);
            check("lat_cycle2", pix_valid, 0);
            tick(1);
            check("lat_cycle3", pix_valid, 1);
        end else begin
            tick(3);
        end
    endtask

    // nibble whose detection cycle coincides with an err_clr pulse
    task automatic nibble_clr(input logic [3:0] d);
        lcd_data = d;
        lcd_cl2  = 1'b1;
        tick(3);
        lcd_cl2 = 1'b0;
        tick(2);
        err_clr = 1'b1;
        md_fmt  = 1'b0;
        md_merr = 1'b0;
        model_dclk(d);
        tick(1);
        err_clr = 1'b0;
        tick(2);
    endtask

    task automatic lp(input bit flm);
        lcd_flm = flm;
        lcd_cl1 = 1'b1;
        tick(3);
        lcd_cl1 = 1'b0;
        model_lp(flm);
        tick(3);
        lcd_flm = 1'b0;
    endtask

    task automatic both(input logic [3:0] d, input bit flm);
        lcd_data = d;
        lcd_flm  = flm;
        lcd_cl1  = 1'b1;
        lcd_cl2  = 1'b1;
        tick(3);
        lcd_cl1 = 1'b0;
        lcd_cl2 = 1'b0;
        model_dclk(d);
        model_lp(flm);
        tick(4);
        lcd_flm = 1'b0;
    endtask

    task automatic line(input int n, input int l);
        for (int i = 0; i < n; i++) nibble(pat(i, l), 1'b0);
        lp(1'b0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        md_fmt  = 1'b0;
        md_merr = 1'b0;
        tick(1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        lcd_flm = 1'b0; lcd_cl1 = 1'b0; lcd_cl2 = 1'b0; lcd_m = 1'b0;
        lcd_data = 4'd0; err_clr = 1'b0;
        model_reset();
        tick(3);

        // reset state
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_line_done", line_done, 0);
        check("rst_locked", locked, 0);
        check("rst_fmt_err", fmt_err, 0);
        check("rst_m_err", m_err, 0);
        rst_n = 1'b1;
        tick(2);

        // traffic before any frame marker is ignored
        nibble(4'h5, 1'b0);
        nibble(4'hA, 1'b0);
        lp(1'b0);
        check("pre_locked", locked, 0);
        check("pre_pix", cnt_pix, 0);
        check_q("pre");

        // full frame: FLM at the first LP, V lines of H nibbles
        p0 = cnt_pix; l0 = cnt_line; f0 = cnt_frame;
        lcd_m = 1'b0;
        lp(1'b1);
        check("fs_locked", locked, 1);
        for (int l = 0; l < V; l++) begin
            for (int i = 0; i < H; i++) nibble(pat(i, l), (l == 0 && i == 0));
            lp(1'b0);
        end
        check("frame_pix_count", cnt_pix - p0, 960);
        check("frame_line_count", cnt_line - l0, 12);
        check("frame_start_count", cnt_frame - f0, 1);
        check("frame_fmt_err", fmt_err, 0);
        check("frame_pix_y_sat", pix_y, 12);
        check_status("frame");
        check_q("frame");

        // saturated: extra data is dropped, error set wins over err_clr
        nibble(4'h3, 1'b0);
        nibble_clr(4'h7);
        check("sat_set_wins", fmt_err, 1);
        lp(1'b0);
        check_status("sat");
        pulse_clr();
        check("sat_cleared", fmt_err, 0);

        // second frame with toggled polarity; saturated restart is clean
        lcd_m = 1'b1;
        lp(1'b1);
        check("f2_m_err", m_err, 0);
        check("f2_fmt_err", fmt_err, 0);
        check_status("f2");

        // 81 nibbles in a line
        p0 = cnt_pix;
        line(81, 0);
        check("long_pix_count", cnt_pix - p0, 80);
        check("long_fmt_err", fmt_err, 1);
        pulse_clr();
        check("long_cleared", fmt_err, 0);

        // last nibble and LP fall in the same cycle
        for (int i = 0; i < H - 1; i++) nibble(pat(i, 1), 1'b0);
        both(4'hC, 1'b0);
        check("same_fmt_err", fmt_err, 0);
        check("same_pix_y", pix_y, 2);
        check_q("same");

        // early frame marker after 5 lines, polarity held
        for (int l = 2; l < 5; l++) line(H, l);
        lp(1'b1);
        check("early_fmt_err", fmt_err, 1);
        check("early_pix_y", pix_y, 0);
`ifdef LCD_RX_M_CHECK_EN
        check("early_m_err", m_err, 1);
`else
        check("early_m_err", m_err, 0);
`endif
        check_status("early");
        pulse_clr();
        check_status("early_clr");

        // reset mid-line, then data resumes without FLM
        line(H, 0);
        line(H, 1);
        for (int i = 0; i < 10; i++) nibble(pat(i, 2), 1'b0);
        lcd_data = 4'h9;
        lcd_cl2  = 1'b1;
        tick(1);
        rst_n = 1'b0;
        model_reset();
        tick(1);
        check("midrst_locked", locked, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        lcd_cl2 = 1'b0;
        model_dclk(4'h9);
        tick(3);
        p0 = cnt_pix;
        for (int i = 11; i < H; i++) nibble(pat(i, 2), 1'b0);
        lp(1'b0);
        line(H, 3);
        check("post_rst_locked", locked, 0);
        check("post_rst_pix", cnt_pix - p0, 0);
        check_q("post_rst");

        // next FLM relocks; first frame after reset skips the polarity check
        lp(1'b1);
        check("relock_locked", locked, 1);
        line(H, 4);
        check_status("relock");
        check_q("relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_rx.md
LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 Parameter H_NIBBLES, default 80, sets the number of 4-bit nibbles per line (320 px).
REQ-002 Parameter V_LINES, default 240, sets the number of lines per frame.
REQ-003 clk  input  1  system sampling clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 lcd_flm  input  1  frame marker from the panel bus.
REQ-006 lcd_cl1  input  1  line latch pulse (LP).
REQ-007 lcd_cl2  input  1  data shift clock (DCLK).
REQ-008 lcd_m  input  1  AC-drive polarity.
REQ-009 lcd_data  input  4  pixel nibble.
REQ-010 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-011 pix_data  output  4  captured nibble.
REQ-012 pix_valid  output  1  one-cycle strobe qualifying pix_data, pix_x and pix_y.
REQ-013 pix_x  output  8  nibble index within the line, 0..H_NIBBLES-1.
REQ-014 pix_y  output  9  line index within the frame, 0..V_LINES-1.
REQ-015 frame_start  output  1  one-cycle pulse at frame start.
REQ-016 line_done  output  1  one-cycle pulse at each line end.
REQ-017 locked  output  1  high while the block is inside a frame.
REQ-018 fmt_err  output  1  sticky flag for a line-length or line-count violation.
REQ-019 m_err  output  1  sticky flag for a polarity violation; tied 0 when LCD_RX_M_CHECK_EN is undefined.

Function
REQ-020 All five bus inputs SHALL pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-021 The block SHALL detect a DCLK falling edge and an LP falling edge from the synchronized signals only.
REQ-022 The block SHALL have a two-state FSM: WAIT_FRAME and IN_FRAME.
REQ-023 WAIT_FRAME to IN_FRAME: on an LP fall with synchronized flm=1, the block SHALL pulse frame_start, set locked=1, and set pix_x=0 and pix_y=0.
REQ-024 In WAIT_FRAME, DCLK edges SHALL be ignored and no pix_valid SHALL be produced.
REQ-025 In IN_FRAME, on a DCLK fall with pix_x<H_NIBBLES, the block SHALL capture the synchronized data and pulse pix_valid; pix_x SHALL increment after the strobe.
REQ-026 pix_valid SHALL rise exactly 3 clk cycles after a DCLK fall at the pin.
REQ-027 Bus inputs SHALL be stable for at least 3 clk cycles on each side of DCLK and LP edges.
REQ-028 A DCLK fall with pix_x=H_NIBBLES SHALL drop the nibble and set fmt_err.
REQ-029 An LP fall with flm=0 SHALL pulse line_done; fmt_err SHALL be set if pix_x!=H_NIBBLES; pix_x SHALL return to 0 and pix_y SHALL increment.
REQ-030 pix_y SHALL saturate at V_LINES; lines arriving at saturation SHALL drop their data and set fmt_err.
REQ-031 An LP fall with flm=1 while IN_FRAME SHALL end the current line as in REQ-029 and restart the frame as in REQ-023.
REQ-032 On that restart, fmt_err SHALL be set if the completed line count !=V_LINES.
REQ-033 When a DCLK fall and an LP fall are detected in the same cycle, the nibble SHALL be captured into the ending line first, then the line SHALL end.
REQ-034 err_clr SHALL clear fmt_err and m_err; a new error event in the same cycle SHALL take priority and leave the flag set.

Reset
REQ-035 On rst_n=0, all outputs, synchronizers, counters and flags SHALL go to 0, and the FSM SHALL enter WAIT_FRAME, regardless of the current bus phase.
REQ-036 After release, no pix_valid SHALL occur before the next frame start.

Configuration
REQ-037 Macro LCD_RX_M_CHECK_EN, when defined, SHALL latch lcd_m at each frame start and set m_err if the value equals the previous frame's value, i.e. lcd_m did not toggle.
REQ-038 The check SHALL skip the first frame after reset.
REQ-039 When LCD_RX_M_CHECK_EN is undefined, m_err SHALL be constant 0 and no polarity logic SHALL be present.

Verification
REQ-040 Full frame, 80 DCLK falls per line, 240 lines, flm at the first LP -> 19200 pix_valid, 240 line_done, one frame_start, fmt_err=0.
REQ-041 Line with 81 DCLK falls -> 80 pix_valid, fmt_err=1; err_clr pulse -> fmt_err=0.
REQ-042 DCLK fall and LP fall in the same cycle on the 80th nibble -> pix_valid with pix_x=79, then line_done, fmt_err=0.
REQ-043 flm reasserted after 100 lines -> frame_start, pix_y=0, fmt_err=1.
REQ-044 rst_n low for 2 cycles mid-line 50, then frame data resumes without flm -> locked=0 and no pix_valid until the next flm LP.
REQ-045 LCD_RX_M_CHECK_EN defined, lcd_m held 1 across two frames -> m_err=1 at the second frame_start; with lcd_m toggling -> m_err=0.
